// File: rtl/eth_rx_frame_ctrl.sv
// Store-and-forward receive frame controller: frames the post-SFD byte stream,
// filters on DA/length/error/overflow, and replays committed frames in order.
module eth_rx_frame_ctrl #(
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned SLOTS    = 8,
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int unsigned MIN_LEN  = 64,
  parameter int unsigned MAX_LEN  = 1518
) (
  input  logic        eth_rx_clk,
  input  logic        eth_rx_rst_n,
  input  logic        eth_rx_dv,
  input  logic        eth_rxerr,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  input  logic        promisc,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped,
  output logic [1:0]  dbg_state
);
  // Output handshake: a byte transfers on a rising edge where out_valid and
  // out_ready are both 1; while out_valid=1 and out_ready=0 all outputs hold.

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(SLOTS);
  localparam int unsigned LW = $clog2(MAX_LEN + 2);

  localparam logic [AW:0]   DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [SW:0]   SLOTS_P = (SW+1)'(SLOTS);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LEN + 1);
  localparam logic [LW-1:0] MIN_L   = LW'(MIN_LEN);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_dv_q;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_cm_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [LW-1:0] r_len;
  logic          r_err;
  logic          r_ovf;
  logic          r_mac_bad;
  logic          r_drop;
  logic [7:0]    r_mem [DEPTH];
  logic [LW-1:0] r_len_fifo [SLOTS];
  logic [SW:0]   r_fwp;
  logic [SW:0]   r_frp;
  logic [LW-1:0] r_rc;
  logic [15:0]   r_ok;
  logic [15:0]   r_drp;

  logic [AW:0]   w_used;
  logic          w_full;
  logic [SW:0]   w_fifo_cnt;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_start;
  logic          w_recv_byte;
  logic          w_wr_en;
  logic          w_len_ok;
  logic          w_accept;
  logic          w_reject;
  logic [7:0]    w_mac_byte;
  logic          w_mac_miss;
  logic [LW-1:0] w_head_len;
  logic          w_rd_fire;

  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_used == DEPTH_P);
  assign w_fifo_cnt   = r_fwp - r_frp;
  assign w_fifo_full  = (w_fifo_cnt == SLOTS_P);
  assign w_fifo_empty = (w_fifo_cnt == '0);
  assign w_len_ok     = (r_len >= MIN_L) && (r_len <= MAX_L);

  always_comb begin
    case (r_len[2:0])
      3'd0:    w_mac_byte = MAC_ADDR[47:40];
      3'd1:    w_mac_byte = MAC_ADDR[39:32];
      3'd2:    w_mac_byte = MAC_ADDR[31:24];
      3'd3:    w_mac_byte = MAC_ADDR[23:16];
      3'd4:    w_mac_byte = MAC_ADDR[15:8];
      default: w_mac_byte = MAC_ADDR[7:0];
    endcase
  end

  // Each DA byte may match either the station address or broadcast.
  assign w_mac_miss = (r_len < LW'(6)) && !promisc &&
                      (rx_byte != w_mac_byte) && (rx_byte != 8'hFF);

  always_ff @(posedge eth_rx_clk) begin
    if (!eth_rx_rst_n) begin
      r_state <= S_IDLE;
      r_dv_q  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_dv_q  <= eth_rx_dv;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!r_dv_q && eth_rx_dv) w_next = S_RECV;
      S_RECV:   if (!eth_rx_dv) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start     = 1'b0;
    w_recv_byte = 1'b0;
    w_wr_en     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: w_start = !r_dv_q && eth_rx_dv;
      S_RECV: begin
        w_recv_byte = rx_byte_valid;
        w_wr_en     = rx_byte_valid && !w_full && !r_drop && !r_ovf;
      end
      S_FINISH: begin
        w_accept = !r_err && !r_ovf && !r_mac_bad && !r_drop && w_len_ok;
        w_reject = !w_accept;
      end
      default: ;
    endcase
  end

  assign dbg_state = r_state;

  always_ff @(posedge eth_rx_clk) begin
    if (!eth_rx_rst_n) begin
      r_wr_ptr  <= '0;
      r_cm_ptr  <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_mac_bad <= 1'b0;
      r_drop    <= 1'b0;
    end else if (w_start) begin
      r_len     <= '0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_mac_bad <= 1'b0;
      r_drop    <= w_fifo_full;
      r_wr_ptr  <= r_cm_ptr;
    end else if (r_state == S_RECV) begin
      if (eth_rxerr) r_err <= 1'b1;
      if (w_recv_byte) begin
        if (r_len != LEN_SAT) r_len <= r_len + LW'(1);
        if (w_mac_miss) r_mac_bad <= 1'b1;
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        else         r_ovf    <= 1'b1;
      end
    end else if (w_accept) begin
      r_cm_ptr <= r_wr_ptr;
    end else if (w_reject) begin
      r_wr_ptr <= r_cm_ptr;
    end
  end

  // Storage arrays carry no reset; emptiness is defined by the pointers.
  always_ff @(posedge eth_rx_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= rx_byte;
    if (w_accept) r_len_fifo[r_fwp[SW-1:0]] <= r_len;
  end

  always_ff @(posedge eth_rx_clk) begin
    if (!eth_rx_rst_n) begin
      r_fwp <= '0;
    end else if (w_accept) begin
      r_fwp <= r_fwp + (SW+1)'(1);
    end
  end

  assign w_head_len = r_len_fifo[r_frp[SW-1:0]];
  assign out_valid  = !w_fifo_empty;
  assign out_data   = r_mem[r_rd_ptr[AW-1:0]];
  assign out_last   = out_valid && (r_rc == (w_head_len - LW'(1)));
  assign w_rd_fire  = out_valid && out_ready;

  always_ff @(posedge eth_rx_clk) begin
    if (!eth_rx_rst_n) begin
      r_rd_ptr <= '0;
      r_rc     <= '0;
      r_frp    <= '0;
    end else if (w_rd_fire) begin
      r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (out_last) begin
        r_rc  <= '0;
        r_frp <= r_frp + (SW+1)'(1);
      end else begin
        r_rc <= r_rc + LW'(1);
      end
    end
  end

  always_ff @(posedge eth_rx_clk) begin
    if (!eth_rx_rst_n) begin
      r_ok  <= '0;
      r_drp <= '0;
    end else begin
      if (w_accept && (r_ok != 16'hFFFF))  r_ok  <= r_ok + 16'd1;
      if (w_reject && (r_drp != 16'hFFFF)) r_drp <= r_drp + 16'd1;
    end
  end

  assign frames_ok      = r_ok;
  assign frames_dropped = r_drp;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl: frames are driven as MII-rate byte
// streams and every output byte is scored against an expected queue.
module tb_eth_rx_frame_ctrl;

  localparam logic [47:0] MAC_OK = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_NO = 48'h02_00_00_00_00_02;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv;
  logic        rxerr;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        promisc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] frames_ok;
  logic [15:0] frames_dropped;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  eth_rx_frame_ctrl dut (
    .eth_rx_clk     (clk),
    .eth_rx_rst_n   (rst_n),
    .eth_rx_dv      (dv),
    .eth_rxerr      (rxerr),
    .rx_byte        (rx_byte),
    .rx_byte_valid  (rx_valid),
    .promisc        (promisc),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .frames_ok      (frames_ok),
    .frames_dropped (frames_dropped),
    .dbg_state      (dbg_state)
  );

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_last   = 0;
  int n_bytes  = 0;
  int seed     = 11;
  int exp_ok   = 0;
  int exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input logic [47:0] da, input int s, input int i);
    if (i < 6) return da[47-8*i -: 8];
    return 8'(s + i);
  endfunction

  // One byte every two cycles after a 16-cycle preamble, as the MII receiver does.
  task automatic send_frame(input int len, input logic [47:0] da, input bit accept,
                            input int err_at, input int rst_at, input bit last_dv_low);
    int s;
    s = seed;
    seed = seed + 37;
    if (accept)
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), byte_at(da, s, i)});
    dv = 1'b1;
    repeat (16) step();
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end
      rx_byte  = byte_at(da, s, i);
      rx_valid = 1'b1;
      rxerr    = (i == err_at);
      if (last_dv_low && (i == len - 1)) dv = 1'b0;
      step();
      rx_valid = 1'b0;
      rxerr    = 1'b0;
      if (i == len - 1) dv = 1'b0;
      else step();
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((exp_q.size() == 0) && !out_valid) break;
      step();
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ok"}, 32'(frames_ok), 32'(exp_ok));
    check({tag, "_drop"}, 32'(frames_dropped), 32'(exp_drop));
  endtask

  logic       stalled = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_last", 32'(out_last), 32'(e[8]));
        end
        n_bytes++;
        if (out_last) n_last++;
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    int b0;
    int l0;
    rst_n = 1'b0; dv = 1'b0; rxerr = 1'b0; rx_byte = 8'h00;
    rx_valid = 1'b0; promisc = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check_counts("rst");
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (4) step();

    // Minimum-length unicast frame, with commit latency
    send_frame(64, MAC_OK, 1'b1, -1, -1, 1'b0);
    @(negedge clk); check("lat_recv", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_finish", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_first", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'h02);
    step();
    exp_ok = 1;
    wait_drain("t1", 400);
    check_counts("t1");

    // Broadcast accepted, foreign DA dropped, then both accepted when promiscuous
    send_frame(64, MAC_BC, 1'b1, -1, -1, 1'b0); repeat (24) step();
    send_frame(64, MAC_NO, 1'b0, -1, -1, 1'b0); repeat (24) step();
    exp_ok = 2; exp_drop = 1;
    wait_drain("t2a", 400);
    check_counts("t2a");
    promisc = 1'b1;
    send_frame(64, MAC_BC, 1'b1, -1, -1, 1'b0); repeat (24) step();
    send_frame(64, MAC_NO, 1'b1, -1, -1, 1'b0); repeat (24) step();
    promisc = 1'b0;
    exp_ok = 4;
    wait_drain("t2b", 400);
    check_counts("t2b");

    // Runt, oversize and PHY error dropped; then good frames at both length limits
    send_frame(60, MAC_OK, 1'b0, -1, -1, 1'b0); repeat (24) step();
    send_frame(1519, MAC_OK, 1'b0, -1, -1, 1'b0); repeat (24) step();
    send_frame(100, MAC_OK, 1'b0, 50, -1, 1'b0); repeat (24) step();
    exp_drop = 4;
    check_counts("t3a");
    send_frame(64, MAC_OK, 1'b1, -1, -1, 1'b1); repeat (24) step();
    send_frame(1518, MAC_OK, 1'b1, -1, -1, 1'b0); repeat (24) step();
    exp_ok = 6;
    wait_drain("t3b", 2000);
    check_counts("t3b");

    // Buffer overflow while the consumer is stalled
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_frame(1500, MAC_OK, f < 2, -1, -1, 1'b0);
      repeat (24) step();
    end
    exp_ok = 8; exp_drop = 5;
    check_counts("t4");
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_head", 32'(out_data), 32'h02);
    b0 = n_bytes; l0 = n_last;
    out_ready = 1'b1;
    wait_drain("t4", 4000);
    check("t4_bytes", 32'(n_bytes - b0), 32'd3000);
    check("t4_lasts", 32'(n_last - l0), 32'd2);

    // Length FIFO full: ninth frame dropped, then throttled drain with a late arrival
    out_ready = 1'b0;
    for (int f = 0; f < 9; f++) begin
      send_frame(64, MAC_OK, f < 8, -1, -1, 1'b0);
      repeat (24) step();
    end
    exp_ok = 16; exp_drop = 6;
    check_counts("t5a");
    b0 = n_bytes; l0 = n_last;
    fork
      begin
        for (int c = 0; c < 1500; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
      begin
        repeat (300) step();
        send_frame(64, MAC_OK, 1'b1, -1, -1, 1'b0);
        repeat (24) step();
      end
    join
    out_ready = 1'b1;
    exp_ok = 17;
    wait_drain("t5", 1500);
    check_counts("t5b");
    check("t5_bytes", 32'(n_bytes - b0), 32'd576);
    check("t5_lasts", 32'(n_last - l0), 32'd9);

    // Reset mid-frame with dv held high through release
    send_frame(64, MAC_OK, 1'b0, -1, 30, 1'b0);
    repeat (24) step();
    exp_ok = 0; exp_drop = 0;
    check_counts("t6a");
    check("t6a_valid", 32'(out_valid), 32'd0);
    send_frame(64, MAC_OK, 1'b1, -1, -1, 1'b0);
    repeat (24) step();
    exp_ok = 1;
    wait_drain("t6", 400);
    check_counts("t6b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
